// File: rtl/vc_allocator_rr_pkg.sv
// Shared NoC sizing for the VC allocator: port/VC counts, index widths and the port index type.
package noc_params;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PORT_NUM  = 5;
  localparam int VC_NUM    = 4;
  localparam int VC_SIZE   = idx_width(VC_NUM);
  localparam int PORT_SIZE = idx_width(PORT_NUM);

  typedef logic [PORT_SIZE-1:0] port_t;

endpackage

// File: rtl/vc_allocator_rr_arb.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer; the pointer moves
// to one past the winner only when the caller reports that the choice became a real grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         update_i,
  output logic [N-1:0] grant_o
);

  localparam int PTR_W = noc_params::idx_width(N);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_win;
  logic             w_found;

  // Two passes: requesters at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && req_i[i] && (PTR_W'(i) >= r_ptr)) begin
        w_win   = PTR_W'(i);
        w_found = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && req_i[i]) begin
        w_win   = PTR_W'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (w_found) grant_o[w_win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (update_i && w_found) begin
      r_ptr <= (w_win == PTR_W'(N - 1)) ? '0 : w_win + PTR_W'(1);
    end
  end

endmodule

// File: rtl/vc_allocator_rr.sv
// Separable input-first VC allocator with per-downstream-port availability tracking.
// Define VC_ALLOC_RR_EN to pick downstream VCs round-robin instead of lowest-index-first.
module vc_allocator_rr #(
  parameter int PORT_NUM = noc_params::PORT_NUM,
  parameter int VC_NUM   = noc_params::VC_NUM
) (
  input  logic                                                              clk,
  input  logic                                                              rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]                                   vc_request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][noc_params::idx_width(PORT_NUM)-1:0] out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]                                   idle_downstream_vc_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]                                   vc_valid_o,
  output logic [PORT_NUM-1:0][VC_NUM-1:0][noc_params::idx_width(VC_NUM)-1:0]   vc_new_o,
  output logic [PORT_NUM-1:0][noc_params::idx_width(VC_NUM):0]              free_vc_count_o
);

  localparam int VC_SIZE   = noc_params::idx_width(VC_NUM);
  localparam int PORT_SIZE = noc_params::idx_width(PORT_NUM);
  localparam int CNT_W     = VC_SIZE + 1;

  logic [PORT_NUM-1:0][VC_NUM-1:0]    r_avail;
  logic [PORT_NUM-1:0][VC_NUM-1:0]    w_avail_nxt;
  logic [PORT_NUM-1:0][CNT_W-1:0]     r_free_cnt;
  logic [PORT_NUM-1:0][CNT_W-1:0]     w_free_cnt_nxt;
  logic [PORT_NUM-1:0]                w_has_free;
  logic [PORT_NUM-1:0][VC_NUM-1:0]    w_elig;
  logic [PORT_NUM-1:0][VC_NUM-1:0]    w_s1_gnt;
  logic [PORT_NUM-1:0]                w_s1_any;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] w_s1_tgt;
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  w_s2_req;
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  w_s2_gnt;
  logic [PORT_NUM-1:0]                w_up_gnt;
  logic [PORT_NUM-1:0]                w_dn_fire;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   w_sel;
  logic [PORT_NUM-1:0]                w_sel_found;

  always_comb begin
    w_has_free = '0;
    for (int d = 0; d < PORT_NUM; d++) w_has_free[d] = |r_avail[d];
  end

  // Out-of-range targets never match any d, so they are silently ineligible.
  always_comb begin
    w_elig = '0;
    for (int u = 0; u < PORT_NUM; u++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        for (int d = 0; d < PORT_NUM; d++) begin
          if (vc_request_i[u][v] && (out_port_i[u][v] == PORT_SIZE'(d)) && w_has_free[d])
            w_elig[u][v] = 1'b1;
        end
      end
    end
  end

  for (genvar gu = 0; gu < PORT_NUM; gu++) begin : g_in_arb
    rr_arbiter #(.N(VC_NUM)) u_in_arb (
      .clk      (clk),
      .rst      (rst),
      .req_i    (w_elig[gu]),
      .update_i (w_up_gnt[gu]),
      .grant_o  (w_s1_gnt[gu])
    );
  end

  always_comb begin
    w_s1_any = '0;
    w_s1_tgt = '0;
    for (int u = 0; u < PORT_NUM; u++) begin
      w_s1_any[u] = |w_s1_gnt[u];
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_s1_gnt[u][v]) w_s1_tgt[u] = out_port_i[u][v];
      end
    end
  end

  // w_s2_req / w_s2_gnt are indexed [downstream][upstream].
  always_comb begin
    w_s2_req = '0;
    for (int d = 0; d < PORT_NUM; d++) begin
      for (int u = 0; u < PORT_NUM; u++) begin
        w_s2_req[d][u] = w_s1_any[u] && (w_s1_tgt[u] == PORT_SIZE'(d));
      end
    end
  end

  for (genvar gd = 0; gd < PORT_NUM; gd++) begin : g_out_arb
    rr_arbiter #(.N(PORT_NUM)) u_out_arb (
      .clk      (clk),
      .rst      (rst),
      .req_i    (w_s2_req[gd]),
      .update_i (w_dn_fire[gd]),
      .grant_o  (w_s2_gnt[gd])
    );
  end

  always_comb begin
    w_dn_fire = '0;
    w_up_gnt  = '0;
    for (int d = 0; d < PORT_NUM; d++) begin
      w_dn_fire[d] = (|w_s2_gnt[d]) && !rst;
      for (int u = 0; u < PORT_NUM; u++) begin
        if (w_s2_gnt[d][u] && !rst) w_up_gnt[u] = 1'b1;
      end
    end
  end

`ifdef VC_ALLOC_RR_EN
  logic [PORT_NUM-1:0][VC_SIZE-1:0] r_vc_ptr;

  // VC_NUM is a power of two, so the VC_SIZE-bit sum wraps modulo VC_NUM.
  always_comb begin
    w_sel       = '0;
    w_sel_found = '0;
    for (int d = 0; d < PORT_NUM; d++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        if (!w_sel_found[d] && r_avail[d][r_vc_ptr[d] + VC_SIZE'(k)]) begin
          w_sel[d]       = r_vc_ptr[d] + VC_SIZE'(k);
          w_sel_found[d] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vc_ptr <= '0;
    end else begin
      for (int d = 0; d < PORT_NUM; d++) begin
        if (w_dn_fire[d]) r_vc_ptr[d] <= w_sel[d] + VC_SIZE'(1);
      end
    end
  end
`else
  always_comb begin
    w_sel       = '0;
    w_sel_found = '0;
    for (int d = 0; d < PORT_NUM; d++) begin
      for (int k = VC_NUM - 1; k >= 0; k--) begin
        if (r_avail[d][k]) begin
          w_sel[d]       = VC_SIZE'(k);
          w_sel_found[d] = 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    vc_valid_o = '0;
    vc_new_o   = '0;
    for (int u = 0; u < PORT_NUM; u++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_up_gnt[u] && w_s1_gnt[u][v]) begin
          vc_valid_o[u][v] = 1'b1;
          for (int d = 0; d < PORT_NUM; d++) begin
            if (w_s2_gnt[d][u]) vc_new_o[u][v] = w_sel[d];
          end
        end
      end
    end
  end

  // Grant clear is applied after idle set so a same-cycle grant wins.
  always_comb begin
    w_avail_nxt    = r_avail | idle_downstream_vc_i;
    w_free_cnt_nxt = '0;
    for (int d = 0; d < PORT_NUM; d++) begin
      if (w_dn_fire[d] && w_sel_found[d]) w_avail_nxt[d][w_sel[d]] = 1'b0;
    end
    for (int d = 0; d < PORT_NUM; d++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        w_free_cnt_nxt[d] = w_free_cnt_nxt[d] + CNT_W'(w_avail_nxt[d][v]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_avail <= '1;
      for (int d = 0; d < PORT_NUM; d++) r_free_cnt[d] <= CNT_W'(VC_NUM);
    end else begin
      r_avail    <= w_avail_nxt;
      r_free_cnt <= w_free_cnt_nxt;
    end
  end

  assign free_vc_count_o = r_free_cnt;

endmodule

// File: tb/tb_vc_allocator_rr.sv
// Bench for vc_allocator_rr: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a list-based allocation model.
module tb_vc_allocator_rr;

  localparam int P  = 5;
  localparam int V  = 4;
  localparam int VS = 2;
  localparam int PS = 3;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  logic [P-1:0][V-1:0]         vc_request_i;
  logic [P-1:0][V-1:0][PS-1:0] out_port_i;
  logic [P-1:0][V-1:0]         idle_downstream_vc_i;
  logic [P-1:0][V-1:0]         vc_valid_o;
  logic [P-1:0][V-1:0][VS-1:0] vc_new_o;
  logic [P-1:0][CW-1:0]        free_vc_count_o;

  vc_allocator_rr #(.PORT_NUM(P), .VC_NUM(V)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .vc_request_i         (vc_request_i),
    .out_port_i           (out_port_i),
    .idle_downstream_vc_i (idle_downstream_vc_i),
    .vc_valid_o           (vc_valid_o),
    .vc_new_o             (vc_new_o),
    .free_vc_count_o      (free_vc_count_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: free flags per downstream VC and the three kinds of rotation pointer.
  int m_avail[P][V];
  int m_pin[P];
  int m_pout[P];
  int m_vptr[P];
  int s1win[P];
  int s2win[P];
  int vcsel[P];
  logic pred_rst = 1'b1;

  logic [P-1:0][V-1:0]         exp_valid, obs_valid;
  logic [P-1:0][V-1:0][VS-1:0] exp_new, obs_new;
  logic [P-1:0][CW-1:0]        exp_cnt, obs_cnt, all4;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_free(input int d);
    int n = 0;
    for (int v = 0; v < V; v++) n += m_avail[d][v];
    return n;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < P; d++) begin
      for (int v = 0; v < V; v++) m_avail[d][v] = 1;
      m_pin[d]  = 0;
      m_pout[d] = 0;
      m_vptr[d] = 0;
      s1win[d]  = -1;
      s2win[d]  = -1;
      vcsel[d]  = -1;
    end
  endtask

  task automatic predict();
    int v, t, u, base;
    for (int a = 0; a < P; a++) begin
      s1win[a] = -1;
      for (int k = 0; k < V; k++) begin
        v = (m_pin[a] + k) % V;
        t = int'(out_port_i[a][v]);
        if (s1win[a] < 0 && vc_request_i[a][v] && t < P && m_free(t) > 0) s1win[a] = v;
      end
    end
    exp_valid = '0;
    exp_new   = '0;
    for (int d = 0; d < P; d++) begin
      s2win[d] = -1;
      vcsel[d] = -1;
      for (int k = 0; k < P; k++) begin
        u = (m_pout[d] + k) % P;
        if (s2win[d] < 0 && s1win[u] >= 0 && int'(out_port_i[u][s1win[u]]) == d) s2win[d] = u;
      end
      if (s2win[d] >= 0) begin
`ifdef VC_ALLOC_RR_EN
        base = m_vptr[d];
`else
        base = 0;
`endif
        for (int k = 0; k < V; k++) begin
          v = (base + k) % V;
          if (vcsel[d] < 0 && m_avail[d][v] == 1) vcsel[d] = v;
        end
        exp_valid[s2win[d]][s1win[s2win[d]]] = 1'b1;
        exp_new[s2win[d]][s1win[s2win[d]]]   = VS'(vcsel[d]);
      end
    end
  endtask

  task automatic model_update();
    int u;
    for (int d = 0; d < P; d++)
      for (int v = 0; v < V; v++)
        if (idle_downstream_vc_i[d][v]) m_avail[d][v] = 1;
    for (int d = 0; d < P; d++) begin
      if (s2win[d] >= 0) begin
        u = s2win[d];
        m_avail[d][vcsel[d]] = 0;
        m_pout[d] = (u + 1) % P;
        m_pin[u]  = (s1win[u] + 1) % V;
        m_vptr[d] = (vcsel[d] + 1) % V;
      end
    end
  endtask

  // Compare process: predict from the model and check the DUT every cycle.
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      pred_rst  = 1'b1;
      exp_valid = '0;
      exp_new   = '0;
    end else begin
      pred_rst = 1'b0;
      predict();
    end
    for (int d = 0; d < P; d++) exp_cnt[d] = CW'(m_free(d));
    obs_valid = vc_valid_o;
    obs_new   = vc_new_o;
    obs_cnt   = free_vc_count_o;
    check("model_valid", 64'(obs_valid), 64'(exp_valid));
    check("model_new",   64'(obs_new),   64'(exp_new));
    check("model_count", 64'(obs_cnt),   64'(exp_cnt));
  end

  always @(posedge clk) begin
    if (!rst && !pred_rst) model_update();
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    vc_request_i         = '0;
    out_port_i           = '0;
    idle_downstream_vc_i = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic set_req(input int u, input int v, input int port);
    vc_request_i[u][v] = 1'b1;
    out_port_i[u][v]   = PS'(port);
  endtask

  initial begin
    noc_params::port_t rp;
    for (int d = 0; d < P; d++) all4[d] = CW'(V);
    rst = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    sample();
    check("reset_count", 64'(obs_cnt), 64'(all4));
    check("reset_valid", 64'(obs_valid), 64'd0);
    next_cycle();

    // Single request, zero-latency grant, count drops on the next edge.
    set_req(0, 0, 2);
    sample();
    check("first_valid", 64'(obs_valid[0][0]), 64'd1);
    check("first_new", 64'(obs_new[0][0]), 64'd0);
    next_cycle();
    clear_in();
    sample();
    check("first_count2", 64'(obs_cnt[2]), 64'd3);
    next_cycle();

    // Two upstream ports contend for port 3 over two cycles.
    set_req(0, 0, 3);
    set_req(1, 0, 3);
    sample();
    check("contend_c1_p0", 64'(obs_valid[0][0]), 64'd1);
    check("contend_c1_p1", 64'(obs_valid[1][0]), 64'd0);
    next_cycle();
    sample();
    check("contend_c2_p1", 64'(obs_valid[1][0]), 64'd1);
    check("contend_c2_p0", 64'(obs_valid[0][0]), 64'd0);
    check("contend_c2_new", 64'(obs_new[1][0]), 64'd1);
    next_cycle();

    // Exhaust port 4, then recycle VC 2.
    do_reset();
    set_req(0, 0, 4);
    for (int k = 0; k < 4; k++) begin
      sample();
      check("exhaust_valid", 64'(obs_valid[0][0]), 64'd1);
      check("exhaust_new", 64'(obs_new[0][0]), 64'(k));
      next_cycle();
    end
    sample();
    check("exhausted_valid", 64'(obs_valid[0][0]), 64'd0);
    check("exhausted_count", 64'(obs_cnt[4]), 64'd0);
    next_cycle();
    idle_downstream_vc_i[4][2] = 1'b1;
    sample();
    check("idle_cycle_valid", 64'(obs_valid[0][0]), 64'd0);
    next_cycle();
    idle_downstream_vc_i = '0;
    sample();
    check("reuse_valid", 64'(obs_valid[0][0]), 64'd1);
    check("reuse_new", 64'(obs_new[0][0]), 64'd2);
    next_cycle();

    // Downstream VC choice after selective frees.
    do_reset();
    set_req(0, 0, 2);
    repeat (4) begin
      sample();
      next_cycle();
    end
    clear_in();
    idle_downstream_vc_i[2][1] = 1'b1;
    sample();
    next_cycle();
    clear_in();
    set_req(0, 0, 2);
    sample();
    check("free1_valid", 64'(obs_valid[0][0]), 64'd1);
    check("free1_new", 64'(obs_new[0][0]), 64'd1);
    next_cycle();
    do_reset();
    set_req(0, 0, 2);
    sample();
    next_cycle();
    clear_in();
    idle_downstream_vc_i[2][0] = 1'b1;
    idle_downstream_vc_i[2][1] = 1'b1;
    sample();
    next_cycle();
    clear_in();
    set_req(0, 0, 2);
    sample();
`ifdef VC_ALLOC_RR_EN
    check("free01_new", 64'(obs_new[0][0]), 64'd1);
`else
    check("free01_new", 64'(obs_new[0][0]), 64'd0);
`endif
    next_cycle();

    // Out-of-range target port.
    do_reset();
    set_req(1, 2, 7);
    sample();
    check("badport_valid", 64'(obs_valid), 64'd0);
    next_cycle();
    clear_in();
    sample();
    check("badport_count", 64'(obs_cnt), 64'(all4));
    next_cycle();

    // Reset in the middle of a burst.
    set_req(0, 0, 1);
    repeat (3) begin
      sample();
      next_cycle();
    end
    clear_in();
    sample();
    check("burst_count1", 64'(obs_cnt[1]), 64'd1);
    next_cycle();
    set_req(0, 0, 1);
    rst = 1'b1;
    sample();
    check("midrst_valid", 64'(obs_valid), 64'd0);
    check("midrst_count", 64'(obs_cnt), 64'(all4));
    next_cycle();
    rst = 1'b0;
    clear_in();
    sample();
    check("postrst_count", 64'(obs_cnt), 64'(all4));
    next_cycle();

    // Random traffic, including illegal targets, idles and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      for (int u = 0; u < P; u++) begin
        for (int v = 0; v < V; v++) begin
          vc_request_i[u][v]         = ($urandom_range(0, 9) < 4);
          rp                         = PS'($urandom_range(0, 6));
          out_port_i[u][v]           = rp;
          idle_downstream_vc_i[u][v] = ($urandom_range(0, 9) < 2);
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      next_cycle();
    end
    rst = 1'b0;
    clear_in();
    repeat (2) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
